e203_exu_flush_sched: RTL and testbench
=======================================

E203_EXU_FLUSH_SCHED -- requirements
Module: e203_exu_flush_sched

Interface
REQ-001 SHALL have parameter PC_W, default 32, flush-target operand width (matches E203_PC_SIZE).
REQ-002 SHALL have parameter CNT_W, default 16, flush-event counter width.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports excp_req input 1, excp_op1 input PC_W, excp_op2 input PC_W, excp_ack output 1: exception/IRQ flush requester (priority 0, highest).
REQ-006 SHALL have ports brch_req input 1, brch_op1 input PC_W, brch_op2 input PC_W, brch_ack output 1: branch-mispredict/mret/dret flush requester (priority 1).
REQ-007 SHALL have ports dbg_req input 1, dbg_op1 input PC_W, dbg_op2 input PC_W, dbg_ack output 1: debug-entry flush requester (priority 2, lowest).
REQ-008 SHALL have ports pipe_flush_req output 1, pipe_flush_add_op1 output PC_W, pipe_flush_add_op2 output PC_W, pipe_flush_ack input 1: the single IFU flush port.
REQ-009 SHALL have port flush_pulse  output  1  high in the cycle pipe_flush_req & pipe_flush_ack.
REQ-010 SHALL have port flush_src  output  2  source of current grant: 0 excp, 1 brch, 2 dbg, 3 none.
REQ-011 SHALL have port busy  output  1  high while in ISSUE state.
REQ-012 SHALL have ports cnt_clr input 1 and flush_cnt output CNT_W: completed-flush counter and synchronous clear.

Function
REQ-013 SHALL implement two states: IDLE and ISSUE.
REQ-014 In IDLE with any *_req high, SHALL select the highest-priority active requester, register its op1/op2 and flush_src, and enter ISSUE next cycle (1-cycle request-to-pipe_flush_req latency).
REQ-015 In ISSUE, pipe_flush_req SHALL be 1 and pipe_flush_add_op1/op2 and flush_src SHALL hold the latched values, stable until ack.
REQ-016 Grants SHALL be non-preemptive: a higher-priority request arriving in ISSUE waits; latched operands do not change.
REQ-017 Requester *_ack for the granted source SHALL be combinational: pipe_flush_req & pipe_flush_ack & (flush_src == that source); other acks 0.
REQ-018 Requesters hold *_req and operands until their *_ack; the block SHALL ignore operand changes after latching.
REQ-019 On the ack cycle, if any requester other than the just-acked one has *_req high, the block SHALL latch the highest-priority such requester and remain in ISSUE (back-to-back, no idle bubble); otherwise it SHALL return to IDLE.
REQ-020 The just-acked requester SHALL be excluded from selection in its ack cycle; its request is re-arbitrated from IDLE only if it remains high the following cycle.
REQ-021 In IDLE, pipe_flush_req SHALL be 0, flush_src SHALL be 3, and busy SHALL be 0.
REQ-022 flush_cnt SHALL increment by 1 on each flush_pulse and saturate at all-ones; cnt_clr SHALL zero it next cycle and take priority over a same-cycle increment.
REQ-023 A requester dropping *_req in ISSUE without ack is a protocol violation; the block SHALL still complete the latched flush.

Reset
REQ-024 While rst is high, the block SHALL asynchronously force IDLE, pipe_flush_req 0, pipe_flush_add_op1/op2 0, flush_src 3, busy 0, and flush_cnt 0; all *_ack and flush_pulse SHALL be 0.
REQ-025 rst asserted mid-ISSUE SHALL abandon the pending flush, and no ack SHALL be issued for it.
REQ-026 After rst deasserts, the first grant SHALL occur no earlier than the first rising edge with rst low.

Verification
REQ-027 Single request: brch_req=1, op1=0x8000_0100, op2=0x4 at cycle 0, ack at cycle 3 -> pipe_flush_req high cycles 1-3 with ops 0x8000_0100/0x4, flush_src=1, brch_ack=1 only in cycle 3, flush_cnt=1.
REQ-028 Simultaneous: excp_req, brch_req, dbg_req all high at cycle 0, ack held high -> grants excp (cycle 1), brch (cycle 2), dbg (cycle 3), back-to-back with no bubble, flush_cnt=3.
REQ-029 No preemption: dbg granted; excp_req rises before ack -> ops remain dbg values until dbg_ack; excp granted in the ack cycle's next state.
REQ-030 Reset mid-op: rst pulsed during ISSUE with ack=0 -> outputs go to reset values immediately; no *_ack is observed; flush_cnt=0.
REQ-031 Counter: CNT_W=2, five completed flushes -> flush_cnt saturates at 3; cnt_clr asserted with flush_pulse in the same cycle -> flush_cnt=0.

Source files
------------

// File: rtl/e203_exu_flush_sched.sv
// e203_exu_flush_sched
// Arbitrates three flush requesters (exception/IRQ, branch/mret/dret, debug
// entry) onto the single IFU flush port. It uses a fixed priority of
// excp > brch > dbg. A grant is never pre-empted. A new grant can be taken in
// the same cycle as an ack, so back-to-back flushes need no idle bubble.
//
// Ports
//   clk, rst                         clock, async active-high reset
//   {excp,brch,dbg}_req/op1/op2      requester flush request + target operands
//   {excp,brch,dbg}_ack              combinational ack to the granted requester
//   pipe_flush_req/add_op1/add_op2   flush request + latched operands to IFU
//   pipe_flush_ack                   IFU accepts the flush
//   flush_pulse                      one cycle per completed flush
//   flush_src                        granted source: 0 excp, 1 brch, 2 dbg, 3 none
//   busy                             high while a flush is outstanding
//   cnt_clr, flush_cnt               saturating completed-flush counter + clear
//
// state  | meaning
// IDLE   | no flush outstanding, flush_src = 3
// ISSUE  | pipe_flush_req high with latched operands, waiting for ack
module e203_exu_flush_sched #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             excp_req,
  input  logic [PC_W-1:0]  excp_op1,
  input  logic [PC_W-1:0]  excp_op2,
  output logic             excp_ack,
  input  logic             brch_req,
  input  logic [PC_W-1:0]  brch_op1,
  input  logic [PC_W-1:0]  brch_op2,
  output logic             brch_ack,
  input  logic             dbg_req,
  input  logic [PC_W-1:0]  dbg_op1,
  input  logic [PC_W-1:0]  dbg_op2,
  output logic             dbg_ack,
  output logic             pipe_flush_req,
  output logic [PC_W-1:0]  pipe_flush_add_op1,
  output logic [PC_W-1:0]  pipe_flush_add_op2,
  input  logic             pipe_flush_ack,
  output logic             flush_pulse,
  output logic [1:0]       flush_src,
  output logic             busy,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ISSUE = 1'b1;

  localparam logic [1:0] SRC_EXCP = 2'd0;
  localparam logic [1:0] SRC_BRCH = 2'd1;
  localparam logic [1:0] SRC_DBG  = 2'd2;
  localparam logic [1:0] SRC_NONE = 2'd3;

  logic [0:0]       state_q;
  logic [1:0]       src_q;
  logic [PC_W-1:0]  op1_q;
  logic [PC_W-1:0]  op2_q;
  logic [CNT_W-1:0] cnt_q;

  logic             fire;
  logic             cand_excp;
  logic             cand_brch;
  logic             cand_dbg;
  logic             any_cand;
  logic             take;
  logic [1:0]       sel_src;
  logic [PC_W-1:0]  sel_op1;
  logic [PC_W-1:0]  sel_op2;

  always_comb begin
    fire      = (state_q == S_ISSUE) & pipe_flush_ack;
    // The requester acked this cycle still shows its req until the next
    // edge, so it is masked out to avoid granting it twice.
    cand_excp = excp_req & ~(fire & (src_q == SRC_EXCP));
    cand_brch = brch_req & ~(fire & (src_q == SRC_BRCH));
    cand_dbg  = dbg_req  & ~(fire & (src_q == SRC_DBG));
    any_cand  = cand_excp | cand_brch | cand_dbg;
    // Arbitration only happens when nothing is held: in IDLE, or on the ack.
    take      = (state_q == S_IDLE) | fire;

    sel_src = SRC_DBG;
    sel_op1 = dbg_op1;
    sel_op2 = dbg_op2;
    if (cand_excp) begin
      sel_src = SRC_EXCP;
      sel_op1 = excp_op1;
      sel_op2 = excp_op2;
    end else if (cand_brch) begin
      sel_src = SRC_BRCH;
      sel_op1 = brch_op1;
      sel_op2 = brch_op2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      src_q   <= SRC_NONE;
      op1_q   <= '0;
      op2_q   <= '0;
    end else if (take) begin
      if (any_cand) begin
        state_q <= S_ISSUE;
        src_q   <= sel_src;
        op1_q   <= sel_op1;
        op2_q   <= sel_op2;
      end else begin
        state_q <= S_IDLE;
        src_q   <= SRC_NONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (fire && !(&cnt_q)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign pipe_flush_req     = (state_q == S_ISSUE);
  assign busy               = (state_q == S_ISSUE);
  assign pipe_flush_add_op1 = op1_q;
  assign pipe_flush_add_op2 = op2_q;
  assign flush_src          = src_q;
  assign flush_pulse        = fire;
  assign excp_ack           = fire & (src_q == SRC_EXCP);
  assign brch_ack           = fire & (src_q == SRC_BRCH);
  assign dbg_ack            = fire & (src_q == SRC_DBG);
  assign flush_cnt          = cnt_q;

endmodule

// File: tb/tb_e203_exu_flush_sched.sv
module tb_e203_exu_flush_sched;

  localparam int PC_W  = 32;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             excp_req, brch_req, dbg_req;
  logic [PC_W-1:0]  excp_op1, excp_op2, brch_op1, brch_op2, dbg_op1, dbg_op2;
  logic             excp_ack, brch_ack, dbg_ack;
  logic             pipe_flush_req;
  logic [PC_W-1:0]  pipe_flush_add_op1, pipe_flush_add_op2;
  logic             pipe_flush_ack;
  logic             flush_pulse;
  logic [1:0]       flush_src;
  logic             busy;
  logic             cnt_clr;
  logic [CNT_W-1:0] flush_cnt;

  e203_exu_flush_sched #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .excp_req(excp_req), .excp_op1(excp_op1), .excp_op2(excp_op2), .excp_ack(excp_ack),
    .brch_req(brch_req), .brch_op1(brch_op1), .brch_op2(brch_op2), .brch_ack(brch_ack),
    .dbg_req(dbg_req), .dbg_op1(dbg_op1), .dbg_op2(dbg_op2), .dbg_ack(dbg_ack),
    .pipe_flush_req(pipe_flush_req), .pipe_flush_add_op1(pipe_flush_add_op1),
    .pipe_flush_add_op2(pipe_flush_add_op2), .pipe_flush_ack(pipe_flush_ack),
    .flush_pulse(flush_pulse), .flush_src(flush_src), .busy(busy),
    .cnt_clr(cnt_clr), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]      src;
    logic [PC_W-1:0] op1;
    logic [PC_W-1:0] op2;
  } flush_t;

  flush_t exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [1:0] s, input logic [PC_W-1:0] a, input logic [PC_W-1:0] b);
    flush_t f;
    f.src = s;
    f.op1 = a;
    f.op2 = b;
    exp_q.push_back(f);
  endtask

  // One clock cycle. A requester drops its req right after the edge that
  // follows its ack.
  task automatic step();
    logic ea, ba, da;
    @(negedge clk);
    ea = excp_ack;
    ba = brch_ack;
    da = dbg_ack;
    @(posedge clk);
    #1;
    if (ea) excp_req = 1'b0;
    if (ba) brch_req = 1'b0;
    if (da) dbg_req  = 1'b0;
  endtask

  // Scoreboard monitor: every completed flush must match the oldest expected one.
  initial begin
    flush_t e;
    logic [2:0] exp_ack;
    forever begin
      @(negedge clk);
      if (pipe_flush_req && pipe_flush_ack) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_flush: got src %0d op1 %0h expected no flush", flush_src, pipe_flush_add_op1);
        end else begin
          e = exp_q.pop_front();
          case (e.src)
            2'd0:    exp_ack = 3'b100;
            2'd1:    exp_ack = 3'b010;
            2'd2:    exp_ack = 3'b001;
            default: exp_ack = 3'b000;
          endcase
          chk("sb_src", flush_src, e.src);
          chk("sb_op1", pipe_flush_add_op1, e.op1);
          chk("sb_op2", pipe_flush_add_op2, e.op2);
          chk("sb_acks", {excp_ack, brch_ack, dbg_ack}, exp_ack);
          chk("sb_pulse", flush_pulse, 1'b1);
        end
      end else if (excp_ack || brch_ack || dbg_ack || flush_pulse) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_ack: got acks %b pulse %b expected 000/0", {excp_ack, brch_ack, dbg_ack}, flush_pulse);
      end
    end
  end

  initial begin
    rst = 1'b1;
    excp_req = 0; brch_req = 0; dbg_req = 0;
    excp_op1 = '0; excp_op2 = '0; brch_op1 = '0; brch_op2 = '0; dbg_op1 = '0; dbg_op2 = '0;
    pipe_flush_ack = 0;
    cnt_clr = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", pipe_flush_req, 1'b0);
    chk("rst_src", flush_src, 2'd3);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cnt", flush_cnt, 2'd0);
    chk("rst_op1", pipe_flush_add_op1, 32'h0);
    rst = 1'b0;
    step();

    // Single branch flush, ack in cycle 3
    brch_req = 1; brch_op1 = 32'h8000_0100; brch_op2 = 32'h4;
    push(2'd1, 32'h8000_0100, 32'h4);
    chk("single_c0_req", pipe_flush_req, 1'b0);
    step();
    chk("single_c1_req", pipe_flush_req, 1'b1);
    chk("single_c1_src", flush_src, 2'd1);
    chk("single_c1_busy", busy, 1'b1);
    chk("single_c1_op1", pipe_flush_add_op1, 32'h8000_0100);
    chk("single_c1_op2", pipe_flush_add_op2, 32'h4);
    step();
    chk("single_c2_req", pipe_flush_req, 1'b1);
    step();
    pipe_flush_ack = 1;
    #1;
    chk("single_c3_brch_ack", brch_ack, 1'b1);
    step();
    pipe_flush_ack = 0;
    chk("single_c4_req", pipe_flush_req, 1'b0);
    chk("single_c4_src", flush_src, 2'd3);
    chk("single_cnt", flush_cnt, 2'd1);
    cnt_clr = 1;
    step();
    cnt_clr = 0;
    chk("clr_cnt", flush_cnt, 2'd0);

    // Simultaneous requests, ack held: excp, brch, dbg back to back
    excp_req = 1; excp_op1 = 32'h0000_0E00; excp_op2 = 32'h10;
    brch_req = 1; brch_op1 = 32'h0000_0B00; brch_op2 = 32'h20;
    dbg_req  = 1; dbg_op1  = 32'h0000_0D00; dbg_op2  = 32'h30;
    pipe_flush_ack = 1;
    push(2'd0, 32'h0000_0E00, 32'h10);
    push(2'd1, 32'h0000_0B00, 32'h20);
    push(2'd2, 32'h0000_0D00, 32'h30);
    step();
    chk("simul_c1_src", flush_src, 2'd0);
    step();
    chk("simul_c2_req", pipe_flush_req, 1'b1);
    chk("simul_c2_src", flush_src, 2'd1);
    step();
    chk("simul_c3_req", pipe_flush_req, 1'b1);
    chk("simul_c3_src", flush_src, 2'd2);
    step();
    pipe_flush_ack = 0;
    chk("simul_c4_req", pipe_flush_req, 1'b0);
    chk("simul_cnt", flush_cnt, 2'd3);
    cnt_clr = 1;
    step();
    cnt_clr = 0;

    // No preemption: dbg holds the grant while excp waits
    dbg_req = 1; dbg_op1 = 32'h0000_1111; dbg_op2 = 32'h0000_2222;
    push(2'd2, 32'h0000_1111, 32'h0000_2222);
    step();
    excp_req = 1; excp_op1 = 32'h0000_3333; excp_op2 = 32'h0000_4444;
    dbg_op1 = 32'hDEAD_BEEF;
    push(2'd0, 32'h0000_3333, 32'h0000_4444);
    step();
    chk("nopre_src", flush_src, 2'd2);
    chk("nopre_op1", pipe_flush_add_op1, 32'h0000_1111);
    pipe_flush_ack = 1;
    step();
    chk("nopre_next_src", flush_src, 2'd0);
    chk("nopre_next_req", pipe_flush_req, 1'b1);
    step();
    pipe_flush_ack = 0;
    chk("nopre_done_req", pipe_flush_req, 1'b0);
    chk("nopre_cnt", flush_cnt, 2'd2);

    // Reset during ISSUE with no ack: flush abandoned, nothing acked
    brch_req = 1; brch_op1 = 32'h0000_5555; brch_op2 = 32'h8;
    step();
    step();
    chk("rmid_busy_before", busy, 1'b1);
    rst = 1;
    #1;
    chk("rmid_req", pipe_flush_req, 1'b0);
    chk("rmid_src", flush_src, 2'd3);
    chk("rmid_busy", busy, 1'b0);
    chk("rmid_op1", pipe_flush_add_op1, 32'h0);
    chk("rmid_cnt", flush_cnt, 2'd0);
    pipe_flush_ack = 1;
    #1;
    chk("rmid_acks", {excp_ack, brch_ack, dbg_ack, flush_pulse}, 4'b0000);
    brch_req = 0;
    step();
    pipe_flush_ack = 0;
    rst = 0;
    step();
    step();
    chk("rmid_after_req", pipe_flush_req, 1'b0);

    // Counter saturation at CNT_W=2
    for (int i = 0; i < 5; i++) begin
      excp_req = 1; excp_op1 = 32'h100 + 32'(i); excp_op2 = 32'(i);
      pipe_flush_ack = 1;
      push(2'd0, 32'h100 + 32'(i), 32'(i));
      step();
      step();
      chk("sat_cnt", flush_cnt, (i < 3) ? 64'(i + 1) : 64'd3);
    end
    // Clear has priority over a same-cycle increment
    excp_req = 1; excp_op1 = 32'h0000_0777; excp_op2 = 32'h1;
    push(2'd0, 32'h0000_0777, 32'h1);
    step();
    cnt_clr = 1;
    #1;
    chk("clr_pulse_same", flush_pulse, 1'b1);
    step();
    cnt_clr = 0;
    pipe_flush_ack = 0;
    chk("clr_pri_cnt", flush_cnt, 2'd0);
    step();

    chk("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
